softmax_collect_ctrl: RTL



---
 rtl/softmax_collect_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/softmax_collect_ctrl.sv
// Collects per-row softmax output tiles into a group buffer, then drains the group
// one tile column per beat (all rows side by side) over a valid/ready handshake.
module softmax_collect_ctrl #(
  parameter int WIDTH              = 16,
  parameter int COL                = 64,
  parameter int TILE_SIZE          = 8,
  parameter int NUM_CORES_A_Qn_KnT = 2,
  parameter int BLOCK_SIZE         = 2,
  localparam int TOTAL_SOFTMAX_ROW = NUM_CORES_A_Qn_KnT * BLOCK_SIZE,
  localparam int NUM_TILES         = COL / TILE_SIZE,
  localparam int TILE_WIDTH        = WIDTH * TILE_SIZE,
  localparam int CNT_W             = $clog2(NUM_TILES) + 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [TOTAL_SOFTMAX_ROW-1:0]                  softmax_out_valid,
  input  logic [TOTAL_SOFTMAX_ROW-1:0][TILE_WIDTH-1:0]  softmax_tile_out,
  output logic                                          collect_ready,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [TOTAL_SOFTMAX_ROW*TILE_WIDTH-1:0]       out_data,
  output logic [CNT_W-1:0]                              out_tile_idx,
  output logic                                          out_last,
  output logic                                          group_done,
  output logic                                          overflow_err
);

  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM_TILES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TILES - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        row_cnt  [TOTAL_SOFTMAX_ROW];
  logic [CNT_W-1:0]        cnt_next [TOTAL_SOFTMAX_ROW];
  logic [CNT_W-1:0]        drain_idx;
  logic [TILE_WIDTH-1:0]   tile_buf [TOTAL_SOFTMAX_ROW][NUM_TILES];
  logic [TOTAL_SOFTMAX_ROW-1:0] capture;
  logic                    all_full;
  logic                    ovf_hit;
  logic [IDX_W-1:0]        rd_idx;

  // A row captures while it still has room; any tile it cannot take is an overflow.
  always_comb begin
    capture  = '0;
    all_full = 1'b1;
    ovf_hit  = 1'b0;
    for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) begin
      cnt_next[r] = row_cnt[r];
      if (softmax_out_valid[r]) begin
        if (state == COLLECT && row_cnt[r] < FULL) begin
          capture[r]  = 1'b1;
          cnt_next[r] = row_cnt[r] + 1'b1;
        end else begin
          ovf_hit = 1'b1;
        end
      end
      if (cnt_next[r] != FULL) all_full = 1'b0;
    end
  end

  // Tile storage carries no reset; its contents only matter once a row is full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) begin
        if (capture[r]) tile_buf[r][row_cnt[r][IDX_W-1:0]] <= softmax_tile_out[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      collect_ready <= 1'b1;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      drain_idx     <= '0;
      group_done    <= 1'b0;
      overflow_err  <= 1'b0;
      for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) row_cnt[r] <= '0;
    end else begin
      group_done <= 1'b0;
      if (ovf_hit) overflow_err <= 1'b1;
      case (state)
        COLLECT: begin
          for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) row_cnt[r] <= cnt_next[r];
          if (all_full) begin
            state         <= DRAIN;
            collect_ready <= 1'b0;
            out_valid     <= 1'b1;
            drain_idx     <= '0;
            out_last      <= (NUM_TILES == 1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (drain_idx == LAST_IDX) begin
              state         <= COLLECT;
              collect_ready <= 1'b1;
              out_valid     <= 1'b0;
              out_last      <= 1'b0;
              drain_idx     <= '0;
              group_done    <= 1'b1;
              for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) row_cnt[r] <= '0;
            end else begin
              drain_idx <= drain_idx + 1'b1;
              out_last  <= ((drain_idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign out_tile_idx = drain_idx;
  assign rd_idx       = drain_idx[IDX_W-1:0];

  // Row 0 occupies the most significant tile slot of the beat.
  always_comb begin
    out_data = '0;
    for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) begin
      out_data[(TOTAL_SOFTMAX_ROW-r)*TILE_WIDTH-1 -: TILE_WIDTH] = tile_buf[r][rd_idx];
    end
  end

endmodule
